power_level_select: RTL and testbench

- Parametrised successor to the fixed three-mode selector.
- Holds the cooking power level, stepped by the up/down buttons.
- Supports N levels, optional wrap-around, press-edge detection and hold-to-auto-repeat.
- Sits between the debounced button front-end and the magnetron duty-cycle generator; stepping is permitted only while the oven is idle.

---
 rtl/power_level_select.sv | 177 +++++++++++++++++
 tb/tb_power_level_select.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/power_level_select.sv
// -----------------------------------------------------------------------------
// power_level_select
//
// Holds the cooking power level (0..NUM_LEVELS-1) and steps it with the up and
// down buttons. A fresh press steps once on the edge it is seen. Holding a
// single button then gives a first repeat step HOLD_CYCLES edges after the
// press, followed by further steps every REPEAT_CYCLES edges. Stepping is
// allowed only while the oven is idle and no cook start is requested. The
// level either wraps around at the ends or saturates there, selected by WRAP.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   idle         in   oven idle; the level may change only while high
//   start        in   cook start; blocks stepping while high
//   btn_up       in   up button (debounced, synchronous to clk)
//   btn_dwn      in   down button (debounced, synchronous to clk)
//   level        out  current level index (registered)
//   level_onehot out  1 << level
//   mode         out  level + 1, so that code 0 is never valid
//   changed      out  one-cycle pulse after each edge that changes the level
// -----------------------------------------------------------------------------
module power_level_select #(
    parameter int NUM_LEVELS    = 3,
    parameter int DEFAULT_LEVEL = 1,
    parameter int WRAP          = 1,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000,
    localparam int LW = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idle,
    input  logic                  start,
    input  logic                  btn_up,
    input  logic                  btn_dwn,
    output logic [LW-1:0]         level,
    output logic [NUM_LEVELS-1:0] level_onehot,
    output logic [LW:0]           mode,
    output logic                  changed
);

    // The counter must hold HOLD_CYCLES-1 and REPEAT_CYCLES-1.
    localparam int CNT_MAX   = (HOLD_CYCLES > REPEAT_CYCLES)
                             ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                             : ((REPEAT_CYCLES > 2) ? REPEAT_CYCLES : 2);
    localparam int CW        = $clog2(CNT_MAX);
    localparam int HOLD_LAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int REP_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

    localparam logic [LW-1:0] TOP_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] DEF_LEVEL = LW'(DEFAULT_LEVEL);

    localparam logic [1:0] IDLE_WAIT = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] REPEAT    = 2'd2;

    logic [LW-1:0] level_q,  level_d;
    logic          changed_q;
    logic          up_q,     dn_q;
    logic          up_arm_q, dn_arm_q;
    logic          dir_up_q, dir_up_d;
    logic [1:0]    phase_q,  phase_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic en;
    logic up_only, dn_only;
    logic press_up, press_dn;
    logic hold_ok;
    logic do_step, step_up;

    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        en       = idle & ~start;
        up_only  = btn_up & ~btn_dwn;
        dn_only  = btn_dwn & ~btn_up;

        // A press needs a rising edge on exactly one button. The arm flag
        // blocks a button that was already high when reset was released
        // until it has been seen low once.
        press_up = en & up_only & ~up_q & up_arm_q;
        press_dn = en & dn_only & ~dn_q & dn_arm_q;

        // Continue the hold/repeat timing only while the same single button
        // that started it stays down and stepping is enabled.
        hold_ok  = en & (dir_up_q ? up_only : dn_only);

        phase_d  = IDLE_WAIT;
        cnt_d    = '0;
        dir_up_d = dir_up_q;
        do_step  = 1'b0;
        step_up  = dir_up_q;

        if (press_up || press_dn) begin
            do_step  = 1'b1;
            step_up  = press_up;
            dir_up_d = press_up;
            phase_d  = (HOLD_CYCLES > 0) ? HOLD : IDLE_WAIT;
        end else if (hold_ok && phase_q == HOLD) begin
            if (cnt_q == CW'(HOLD_LAST)) begin
                do_step = 1'b1;
                phase_d = REPEAT;
            end else begin
                phase_d = HOLD;
                cnt_d   = cnt_q + CW'(1);
            end
        end else if (hold_ok && phase_q == REPEAT) begin
            phase_d = REPEAT;
            if (cnt_q == CW'(REP_LAST)) begin
                do_step = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Step arithmetic only ever produces codes 0..TOP_LEVEL, so unused
        // codes of a non-power-of-2 level count are never reached. With
        // saturation the level simply stays put at the end.
        level_d = level_q;
        if (do_step) begin
            if (step_up) begin
                if (level_q == TOP_LEVEL) begin
                    level_d = (WRAP != 0) ? '0 : level_q;
                end else begin
                    level_d = level_q + LW'(1);
                end
            end else begin
                if (level_q == '0) begin
                    level_d = (WRAP != 0) ? TOP_LEVEL : level_q;
                end else begin
                    level_d = level_q - LW'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q   <= DEF_LEVEL;
            changed_q <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            up_arm_q  <= 1'b0;
            dn_arm_q  <= 1'b0;
            dir_up_q  <= 1'b1;
            phase_q   <= IDLE_WAIT;
            cnt_q     <= '0;
        end else begin
            level_q   <= level_d;
            changed_q <= (level_d != level_q);
            // Button history follows the pins regardless of enable, so a
            // button held through a cook cycle never looks like a new press.
            up_q      <= btn_up;
            dn_q      <= btn_dwn;
            up_arm_q  <= up_arm_q | ~btn_up;
            dn_arm_q  <= dn_arm_q | ~btn_dwn;
            dir_up_q  <= dir_up_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        level_onehot = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            level_onehot[i] = (level_q == LW'(i));
        end
    end

    assign level   = level_q;
    assign mode    = {1'b0, level_q} + (LW + 1)'(1);
    assign changed = changed_q;

endmodule

// File: tb/tb_power_level_select.sv
// -----------------------------------------------------------------------------
// tb_power_level_select
//
// Three instances share one stimulus stream:
//   u_a : 3 levels, wrap,     hold 4, repeat 2
//   u_b : 3 levels, saturate, hold 4, repeat 2
//   u_c : 5 levels, wrap,     auto-repeat disabled
// A behavioural model (edge-count arithmetic on the press time) predicts every
// output of every instance and is compared on each falling clock edge. Hand
// computed literal checks along the directed sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_power_level_select;

    localparam int CN[3] = '{3, 3, 5};
    localparam int CW[3] = '{1, 0, 1};
    localparam int CH[3] = '{4, 4, 0};
    localparam int CR[3] = '{2, 2, 2};
    localparam int DEF   = 1;

    logic clk = 1'b0;
    logic rst;
    logic idle, start, btn_up, btn_dwn;

    logic [1:0] lvl_a, lvl_b;
    logic [2:0] lvl_c;
    logic [2:0] oh_a, oh_b;
    logic [4:0] oh_c;
    logic [2:0] md_a, md_b;
    logic [3:0] md_c;
    logic       ch_a, ch_b, ch_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    power_level_select #(
        .NUM_LEVELS(3), .DEFAULT_LEVEL(1), .WRAP(1), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
    ) u_a (
        .clk(clk), .rst(rst), .idle(idle), .start(start), .btn_up(btn_up), .btn_dwn(btn_dwn),
        .level(lvl_a), .level_onehot(oh_a), .mode(md_a), .changed(ch_a)
    );

    power_level_select #(
        .NUM_LEVELS(3), .DEFAULT_LEVEL(1), .WRAP(0), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)
    ) u_b (
        .clk(clk), .rst(rst), .idle(idle), .start(start), .btn_up(btn_up), .btn_dwn(btn_dwn),
        .level(lvl_b), .level_onehot(oh_b), .mode(md_b), .changed(ch_b)
    );

    power_level_select #(
        .NUM_LEVELS(5), .DEFAULT_LEVEL(1), .WRAP(1), .HOLD_CYCLES(0), .REPEAT_CYCLES(2)
    ) u_c (
        .clk(clk), .rst(rst), .idle(idle), .start(start), .btn_up(btn_up), .btn_dwn(btn_dwn),
        .level(lvl_c), .level_onehot(oh_c), .mode(md_c), .changed(ch_c)
    );

    int a_lvl[3], a_oh[3], a_md[3], a_ch[3];

    always_comb begin
        a_lvl[0] = int'(lvl_a); a_oh[0] = int'(oh_a); a_md[0] = int'(md_a); a_ch[0] = int'(ch_a);
        a_lvl[1] = int'(lvl_b); a_oh[1] = int'(oh_b); a_md[1] = int'(md_b); a_ch[1] = int'(ch_b);
        a_lvl[2] = int'(lvl_c); a_oh[2] = int'(oh_c); a_md[2] = int'(md_c); a_ch[2] = int'(ch_c);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic int step(input int lvl, input bit up, input int n, input bit wrap);
        if (up) return (lvl == n - 1) ? (wrap ? 0 : lvl) : lvl + 1;
        return (lvl == 0) ? (wrap ? n - 1 : 0) : lvl - 1;
    endfunction

    int edge_n = 0;
    int m_level[3];
    int m_start[3];
    bit m_changed[3], m_active[3], m_dir[3];
    bit m_pu[3], m_pd[3], m_au[3], m_ad[3];

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge rst) begin
        bit en, up_only, dn_only, pu, pd, held;
        int nl, el;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_level[i] <= DEF;  m_changed[i] <= 1'b0; m_active[i] <= 1'b0;
                m_dir[i]   <= 1'b1; m_start[i]   <= 0;
                m_pu[i] <= 1'b0; m_pd[i] <= 1'b0; m_au[i] <= 1'b0; m_ad[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                en      = idle && !start;
                up_only = btn_up && !btn_dwn;
                dn_only = btn_dwn && !btn_up;
                pu      = en && up_only && !m_pu[i] && m_au[i];
                pd      = en && dn_only && !m_pd[i] && m_ad[i];
                held    = en && (m_dir[i] ? up_only : dn_only);
                nl      = m_level[i];
                if (pu || pd) begin
                    nl = step(m_level[i], pu, CN[i], CW[i] != 0);
                    m_active[i] <= (CH[i] > 0);
                    m_start[i]  <= edge_n;
                    m_dir[i]    <= pu;
                end else if (m_active[i] && held) begin
                    el = edge_n - m_start[i];
                    if (el >= CH[i] && ((el - CH[i]) % CR[i]) == 0)
                        nl = step(m_level[i], m_dir[i], CN[i], CW[i] != 0);
                end else begin
                    m_active[i] <= 1'b0;
                end
                m_level[i]   <= nl;
                m_changed[i] <= (nl != m_level[i]);
                m_pu[i] <= btn_up;
                m_pd[i] <= btn_dwn;
                m_au[i] <= m_au[i] || !btn_up;
                m_ad[i] <= m_ad[i] || !btn_dwn;
            end
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("level[%0d]", i),   a_lvl[i], m_level[i]);
            check($sformatf("onehot[%0d]", i),  a_oh[i],  1 << m_level[i]);
            check($sformatf("mode[%0d]", i),    a_md[i],  m_level[i] + 1);
            check($sformatf("changed[%0d]", i), a_ch[i],  int'(m_changed[i]));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up);
        if (up) btn_up = 1'b1; else btn_dwn = 1'b1;
        @(negedge clk);
        btn_up  = 1'b0;
        btn_dwn = 1'b0;
        @(negedge clk);
    endtask

    int cnt_a, cnt_b;
    int exp_c[10] = '{2, 3, 4, 0, 1, 2, 3, 4, 0, 1};

    initial begin
        rst = 1'b1; idle = 1'b1; start = 1'b0; btn_up = 1'b0; btn_dwn = 1'b0;
        #2 rst = 1'b0;
        tick(2);
        check("reset_level",  a_lvl[0], 1);
        check("reset_onehot", a_oh[0],  3'b010);
        check("reset_mode",   a_md[0],  2);
        check("reset_changed", a_ch[0], 0);
        rst = 1'b1;
        tick(2);

        // Single presses with wrap / saturate.
        press(1'b1); check("up1_a", a_lvl[0], 2); check("up1_c", a_lvl[2], 2);
        press(1'b1); check("up2_wrap_a", a_lvl[0], 0); check("up2_sat_b", a_lvl[1], 2);
        press(1'b0); check("dn1_wrap_a", a_lvl[0], 2);
        press(1'b0); check("dn2_a", a_lvl[0], 1);
        press(1'b0); check("dn3_a", a_lvl[0], 0); check("dn3_b", a_lvl[1], 0);
        press(1'b1); check("up3_a", a_lvl[0], 1);

        // Hold up for 10 cycles: steps at k, k+4, k+6, k+8.
        btn_up = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ch_a) cnt_a++;
            if (ch_b) cnt_b++;
            if (i == 0) check("hold_k_a",  a_lvl[0], 2);
            if (i == 4) check("hold_k4_a", a_lvl[0], 0);
            if (i == 6) check("hold_k6_a", a_lvl[0], 1);
            if (i == 8) check("hold_k8_a", a_lvl[0], 2);
        end
        btn_up = 1'b0;
        tick(1);
        check("hold_pulses_a", cnt_a, 4);
        check("hold_pulses_b", cnt_b, 1);
        check("hold_sat_b",    a_lvl[1], 2);
        check("hold_norep_c",  a_lvl[2], 2);

        // Lockout by start / idle, and a button held while idle rises.
        start = 1'b1; press(1'b1); start = 1'b0;
        check("start_lock_a", a_lvl[0], 2);
        idle = 1'b0; press(1'b1); idle = 1'b1;
        check("idle_lock_a", a_lvl[0], 2);
        idle = 1'b0; btn_up = 1'b1; tick(2);
        idle = 1'b1; tick(3);
        btn_up = 1'b0; tick(1);
        check("held_into_idle_a", a_lvl[0], 2);

        // Drop idle mid-repeat: steps at k and k+4 only.
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) idle = 1'b0;
        end
        check("idle_drop_a", a_lvl[0], 1);
        idle = 1'b1; tick(3);
        btn_up = 1'b0; tick(1);
        check("idle_back_a", a_lvl[0], 1);

        // Conflicts.
        btn_up = 1'b1; btn_dwn = 1'b1; tick(3);
        btn_up = 1'b0; btn_dwn = 1'b0; tick(1);
        check("both_rise_a", a_lvl[0], 1);
        btn_up = 1'b1; tick(2);
        btn_dwn = 1'b1; tick(6);
        btn_up = 1'b0; btn_dwn = 1'b0; tick(1);
        check("add_down_a", a_lvl[0], 2);

        // Asynchronous reset mid-repeat, button kept high afterwards.
        btn_up = 1'b1; tick(7);
        #2 rst = 1'b0;
        #1;
        check("async_level_a",   a_lvl[0], 1);
        check("async_onehot_a",  a_oh[0],  3'b010);
        check("async_mode_a",    a_md[0],  2);
        check("async_changed_a", a_ch[0],  0);
        check("async_level_c",   a_lvl[2], 1);
        @(negedge clk);
        rst = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ch_a) cnt_a++;
        end
        check("post_reset_held_a", a_lvl[0], 1);
        check("post_reset_pulses", cnt_a, 0);
        btn_up = 1'b0; tick(2);

        // Ten up presses on the 5-level instance.
        for (int p = 0; p < 10; p++) begin
            press(1'b1);
            check($sformatf("c_press%0d", p), a_lvl[2], exp_c[p]);
        end

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
